// File: rtl/core_pkg.sv
// core_pkg: shared core widths, ID control-bundle bit positions and the hardwired zero register.
package core_pkg;
  localparam int CTRL_W = 9;
  localparam int REG_AW = 5;
  localparam int CTRL_ALU_OP    = 8;
  localparam int CTRL_REG_DST   = 7;
  localparam int CTRL_BRANCH    = 6;
  localparam int CTRL_MEMREAD   = 5;
  localparam int CTRL_MEM_2_REG = 4;
  localparam int CTRL_MEMWRITE  = 3;
  localparam int CTRL_ALU_SRC   = 2;
  localparam int CTRL_REG_WRITE = 1;
  localparam int CTRL_JUMP      = 0;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;
endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard: shift register of in-flight loads; flags when an ID source reads a pending load result.
module load_scoreboard import core_pkg::*; #(
  parameter int REG_AW = core_pkg::REG_AW,
  parameter int LOAD_LAT = 1,
  parameter bit ZERO_REG_FREE = 1'b1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              shift_en,
  input  logic              push_vld,
  input  logic [REG_AW-1:0] push_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic              hit
);
  logic [LOAD_LAT-1:0] vld;
  logic [REG_AW-1:0]   rd [LOAD_LAT];
  logic                push_ok;
  assign push_ok = push_vld && !(ZERO_REG_FREE && push_rd == REG_AW'(ZERO_REG));
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld <= '0;
      for (int i = 0; i < LOAD_LAT; i++) rd[i] <= '0;
    end else if (shift_en) begin
      vld[0] <= push_ok;
      rd[0]  <= push_rd;
      for (int i = 1; i < LOAD_LAT; i++) begin
        vld[i] <= vld[i-1];
        rd[i]  <= rd[i-1];
      end
    end
  end
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++)
      if (vld[i] && !(ZERO_REG_FREE && rd[i] == REG_AW'(ZERO_REG)) &&
          ((rd[i] == rs1 && rs1_used) || (rd[i] == rs2 && rs2_used))) hit = 1'b1;
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage load-use stall, branch squash and freeze gating with a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int REG_AW = core_pkg::REG_AW,
  parameter int CTRL_W = core_pkg::CTRL_W,
  parameter int LOAD_LAT = 1,
  parameter bit ZERO_REG_FREE = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              id_mem_read_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic              flush_i,
  input  logic              freeze_i,
  input  logic              cnt_clr_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              hold_pc_o,
  output logic              hold_if_id_o,
  output logic              flush_if_id_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  logic hazard, stall;
  load_scoreboard #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .ZERO_REG_FREE(ZERO_REG_FREE)) u_sb (
    .clk(clk), .arst_n(arst_n), .shift_en(!freeze_i),
    .push_vld(id_mem_read_i && !flush_i && !hazard), .push_rd(id_rd_i),
    .rs1(id_rs1_i), .rs2(id_rs2_i), .rs1_used(id_rs1_used_i), .rs2_used(id_rs2_used_i),
    .hit(hazard)
  );
  // a flush outranks the hazard, so a squashed consumer never stalls
  assign stall         = !freeze_i && !flush_i && hazard;
  assign ctrl_o        = (freeze_i || flush_i || hazard) ? '0 : ctrl_i;
  assign hold_pc_o     = freeze_i || stall;
  assign hold_if_id_o  = freeze_i || stall;
  assign flush_if_id_o = !freeze_i && flush_i;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) stall_cnt_o <= '0;
    else if (!freeze_i) stall_cnt_o <= cnt_clr_i ? '0 : (stall && stall_cnt_o != '1) ? stall_cnt_o + 1'b1 : stall_cnt_o;
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: drives LOAD_LAT=1 and LOAD_LAT=3 instances in lockstep against a queued reference model.
module tb_hazard_stall_ctrl;
  logic clk = 1'b0, arst_n = 1'b0;
  always #5 clk = ~clk;
  logic [8:0] ctrl_i = '0;
  logic       mem_rd = 0, u1 = 0, u2 = 0, fl = 0, fz = 0, clr = 0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [8:0] ctrl_a, ctrl_b;
  logic       hp_a, hp_b, hi_a, hi_b, fi_a, fi_b;
  logic [3:0] cnt_a, cnt_b;
  int checks = 0, failures = 0;
  typedef struct packed {logic [8:0] ctrl; logic hp, hi, fi; logic [3:0] cnt;} exp_t;
  exp_t qa[$], qb[$];
  logic       mv [2][3];
  logic [4:0] mrd [2][3];
  logic [3:0] mc [2];
  hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .arst_n(arst_n), .ctrl_i(ctrl_i), .id_mem_read_i(mem_rd), .id_rd_i(rd),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .flush_i(fl), .freeze_i(fz), .cnt_clr_i(clr), .ctrl_o(ctrl_a), .hold_pc_o(hp_a),
    .hold_if_id_o(hi_a), .flush_if_id_o(fi_a), .stall_cnt_o(cnt_a));
  hazard_stall_ctrl #(.LOAD_LAT(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .arst_n(arst_n), .ctrl_i(ctrl_i), .id_mem_read_i(mem_rd), .id_rd_i(rd),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .flush_i(fl), .freeze_i(fz), .cnt_clr_i(clr), .ctrl_o(ctrl_b), .hold_pc_o(hp_b),
    .hold_if_id_o(hi_b), .flush_if_id_o(fi_b), .stall_cnt_o(cnt_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int lat(input int k);
    return k == 0 ? 1 : 3;
  endfunction
  function automatic logic haz(input int k);
    for (int i = 0; i < lat(k); i++)
      if (mv[k][i] && mrd[k][i] != 0 && ((mrd[k][i] == rs1 && u1) || (mrd[k][i] == rs2 && u2))) return 1'b1;
    return 1'b0;
  endfunction
  function automatic exp_t expect_out(input int k);
    exp_t e;
    logic h = haz(k);
    e.ctrl = (fz || fl || h) ? 9'h0 : ctrl_i;
    e.hp = fz || (!fl && h);
    e.hi = fz || (!fl && h);
    e.fi = !fz && fl;
    e.cnt = mc[k];
    return e;
  endfunction
  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0;
      for (int i = 0; i < 3; i++) begin mv[k][i] = 0; mrd[k][i] = 0; end
    end
  endtask
  task automatic advance_model();
    for (int k = 0; k < 2; k++) begin
      logic h = haz(k);
      if (!fz) begin
        if (clr) mc[k] = 0;
        else if (!fl && h && mc[k] != 4'hf) mc[k] = mc[k] + 1;
        for (int i = lat(k) - 1; i > 0; i--) begin mv[k][i] = mv[k][i-1]; mrd[k][i] = mrd[k][i-1]; end
        mv[k][0] = !fl && !h && mem_rd && rd != 0;
        mrd[k][0] = rd;
      end
    end
  endtask
  task automatic step(input logic m, input logic [4:0] d, s1, s2, input logic a1, a2, f, z, cl, ar);
    exp_t ea, eb;
    @(negedge clk);
    ctrl_i = 9'($urandom_range(1, 511));
    mem_rd = m; rd = d; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2; fl = f; fz = z; clr = cl;
    arst_n = ar;
    if (!ar) clear_model();
    #1;
    qa.push_back(expect_out(0));
    qb.push_back(expect_out(1));
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk("ctrl_a", 32'(ctrl_a), 32'(ea.ctrl)); chk("ctrl_b", 32'(ctrl_b), 32'(eb.ctrl));
    chk("hold_pc_a", 32'(hp_a), 32'(ea.hp)); chk("hold_pc_b", 32'(hp_b), 32'(eb.hp));
    chk("hold_ifid_a", 32'(hi_a), 32'(ea.hi)); chk("hold_ifid_b", 32'(hi_b), 32'(eb.hi));
    chk("flush_a", 32'(fi_a), 32'(ea.fi)); chk("flush_b", 32'(fi_b), 32'(eb.fi));
    chk("cnt_a", 32'(cnt_a), 32'(ea.cnt)); chk("cnt_b", 32'(cnt_b), 32'(eb.cnt));
    @(posedge clk);
    #1;
    if (arst_n) advance_model();
  endtask
  task automatic ld(input logic [4:0] d);
    step(1, d, 5'd30, 5'd31, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic use1(input logic [4:0] s, input int n);
    for (int i = 0; i < n; i++) step(0, 5'd20, s, 5'd21, 1, 1, 0, 0, 0, 1);
  endtask
  initial begin
    clear_model();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    ld(5); use1(5, 4);
    ld(7); for (int i = 0; i < 4; i++) step(0, 5'd20, 5'd22, 5'd7, 1, 1, 0, 0, 0, 1);
    ld(7); step(0, 5'd23, 5'd24, 5'd25, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 5'd20, 5'd22, 5'd7, 1, 1, 0, 0, 0, 1);
    ld(0); use1(0, 2);
    ld(4); for (int i = 0; i < 2; i++) step(0, 5'd20, 5'd4, 5'd21, 0, 1, 0, 0, 0, 1);
    ld(9); step(0, 5'd20, 5'd9, 5'd21, 1, 1, 1, 0, 0, 1); use1(9, 3);
    ld(10); use1(10, 1);
    for (int i = 0; i < 2; i++) step(0, 5'd20, 5'd10, 5'd21, 1, 1, 0, 1, 0, 1);
    use1(10, 3);
    ld(11); use1(11, 1);
    step(0, 5'd20, 5'd11, 5'd21, 1, 1, 0, 0, 0, 0);
    use1(11, 2);
    for (int r = 0; r < 6; r++) begin ld(12); use1(12, 3); end
    ld(12); step(0, 5'd20, 5'd12, 5'd21, 1, 1, 0, 0, 1, 1); use1(12, 3);
    for (int i = 0; i < 80; i++)
      step(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
